// File: rtl/swacc_cm_rsp_arbiter.sv
// swacc_cm_rsp_arbiter
// Packet-level round-robin merge of the four context-management response
// streams (QPC, CQC, EQC, ICM mapping) into the single CEU response channel.
// A source keeps the grant from its first beat until its last beat, so packets
// never interleave. The merged beat is held in a one-entry output register
// that can drain and refill in the same cycle.

`ifndef CEU_CXT_HEAD_WIDTH
`define CEU_CXT_HEAD_WIDTH 128
`endif
`ifndef CEU_CXT_DATA_WIDTH
`define CEU_CXT_DATA_WIDTH 256
`endif

module swacc_cm_rsp_arbiter #(
  parameter int HEAD_WIDTH = `CEU_CXT_HEAD_WIDTH,
  parameter int DATA_WIDTH = `CEU_CXT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  qpc_rsp_valid,
  input  logic                  qpc_rsp_last,
  input  logic [HEAD_WIDTH-1:0] qpc_rsp_head,
  input  logic [DATA_WIDTH-1:0] qpc_rsp_data,
  output logic                  qpc_rsp_ready,

  input  logic                  cqc_rsp_valid,
  input  logic                  cqc_rsp_last,
  input  logic [HEAD_WIDTH-1:0] cqc_rsp_head,
  input  logic [DATA_WIDTH-1:0] cqc_rsp_data,
  output logic                  cqc_rsp_ready,

  input  logic                  eqc_rsp_valid,
  input  logic                  eqc_rsp_last,
  input  logic [HEAD_WIDTH-1:0] eqc_rsp_head,
  input  logic [DATA_WIDTH-1:0] eqc_rsp_data,
  output logic                  eqc_rsp_ready,

  input  logic                  mapping_rsp_valid,
  input  logic                  mapping_rsp_last,
  input  logic [HEAD_WIDTH-1:0] mapping_rsp_head,
  input  logic [DATA_WIDTH-1:0] mapping_rsp_data,
  output logic                  mapping_rsp_ready,

  output logic                  ceu_rsp_valid,
  output logic [HEAD_WIDTH-1:0] ceu_rsp_head,
  output logic                  ceu_rsp_last,
  output logic [DATA_WIDTH-1:0] ceu_rsp_data,
  input  logic                  ceu_rsp_ready,

  output logic [31:0]           rsp_pkt_cnt
);

  typedef enum logic [0:0] {
    IDLE_s = 1'b0,
    LOCK_s = 1'b1
  } state_t;

  state_t                cur_state;
  state_t                next_state_s;
  logic [1:0]            grant_idx;
  logic [1:0]            grant_idx_nxt_s;
  logic [1:0]            rr_ptr;
  logic [1:0]            rr_ptr_nxt_s;

  logic [3:0]            req_vec_s;
  logic [3:0]            ready_vec_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic [HEAD_WIDTH-1:0] sel_head_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  acc_s;
  logic                  xfer_s;
  logic [1:0]            pick_idx_s;

  // First requesting index found when scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  assign req_vec_s  = {mapping_rsp_valid, eqc_rsp_valid, cqc_rsp_valid, qpc_rsp_valid};
  assign pick_idx_s = rr_pick(req_vec_s, rr_ptr);

  // The output register can take a beat when empty or when it drains this cycle.
  assign acc_s  = !ceu_rsp_valid || ceu_rsp_ready;
  assign xfer_s = (cur_state == LOCK_s) && sel_valid_s && acc_s;

  assign qpc_rsp_ready     = ready_vec_s[0];
  assign cqc_rsp_ready     = ready_vec_s[1];
  assign eqc_rsp_ready     = ready_vec_s[2];
  assign mapping_rsp_ready = ready_vec_s[3];

  // Route the granted source's handshake and payload toward the output register.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_head_s  = '0;
    sel_data_s  = '0;
    case (grant_idx)
      2'd0: begin
        sel_valid_s = qpc_rsp_valid;
        sel_last_s  = qpc_rsp_last;
        sel_head_s  = qpc_rsp_head;
        sel_data_s  = qpc_rsp_data;
      end
      2'd1: begin
        sel_valid_s = cqc_rsp_valid;
        sel_last_s  = cqc_rsp_last;
        sel_head_s  = cqc_rsp_head;
        sel_data_s  = cqc_rsp_data;
      end
      2'd2: begin
        sel_valid_s = eqc_rsp_valid;
        sel_last_s  = eqc_rsp_last;
        sel_head_s  = eqc_rsp_head;
        sel_data_s  = eqc_rsp_data;
      end
      2'd3: begin
        sel_valid_s = mapping_rsp_valid;
        sel_last_s  = mapping_rsp_last;
        sel_head_s  = mapping_rsp_head;
        sel_data_s  = mapping_rsp_data;
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_head_s  = '0;
        sel_data_s  = '0;
      end
    endcase
  end

  // Arbitration FSM: grant in IDLE_s, hold the grant in LOCK_s until the last beat moves.
  always_comb begin
    next_state_s    = cur_state;
    grant_idx_nxt_s = grant_idx;
    rr_ptr_nxt_s    = rr_ptr;
    ready_vec_s     = 4'b0000;
    case (cur_state)
      IDLE_s: begin
        if (|req_vec_s) begin
          next_state_s    = LOCK_s;
          grant_idx_nxt_s = pick_idx_s;
        end else begin
          next_state_s    = IDLE_s;
          grant_idx_nxt_s = grant_idx;
        end
      end
      LOCK_s: begin
        ready_vec_s[grant_idx] = acc_s;
        if (xfer_s && sel_last_s) begin
          next_state_s = IDLE_s;
          rr_ptr_nxt_s = grant_idx + 2'd1;
        end else begin
          next_state_s = LOCK_s;
          rr_ptr_nxt_s = rr_ptr;
        end
      end
      default: begin
        next_state_s    = IDLE_s;
        grant_idx_nxt_s = 2'd0;
        rr_ptr_nxt_s    = 2'd0;
      end
    endcase
  end

  // State, grant and priority pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE_s;
      grant_idx <= 2'd0;
      rr_ptr    <= 2'd0;
    end else begin
      cur_state <= next_state_s;
      grant_idx <= grant_idx_nxt_s;
      rr_ptr    <= rr_ptr_nxt_s;
    end
  end

  // One-entry output stage: load on transfer, empty on CEU accept, payload holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ceu_rsp_valid <= 1'b0;
      ceu_rsp_head  <= '0;
      ceu_rsp_data  <= '0;
      ceu_rsp_last  <= 1'b0;
    end else if (xfer_s) begin
      ceu_rsp_valid <= 1'b1;
      ceu_rsp_head  <= sel_head_s;
      ceu_rsp_data  <= sel_data_s;
      ceu_rsp_last  <= sel_last_s;
    end else if (ceu_rsp_ready) begin
      ceu_rsp_valid <= 1'b0;
    end else begin
      ceu_rsp_valid <= ceu_rsp_valid;
    end
  end

  // Count packets whose last beat the CEU accepted; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pkt_cnt <= 32'd0;
    end else if (ceu_rsp_valid && ceu_rsp_ready && ceu_rsp_last) begin
      rsp_pkt_cnt <= rsp_pkt_cnt + 32'd1;
    end else begin
      rsp_pkt_cnt <= rsp_pkt_cnt;
    end
  end

endmodule

// File: tb/tb_swacc_cm_rsp_arbiter.sv
// Bench for swacc_cm_rsp_arbiter: per-source packet drivers, a cycle model of
// the packet-level round-robin rules checked every cycle, and directed
// scenarios with hand-computed expectations.

module tb_swacc_cm_rsp_arbiter;
  localparam int HW = 128;
  localparam int DW = 256;

  typedef struct {
    logic [HW-1:0] head;
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ceu_ready = 1'b1;

  wire [3:0]    src_ready;
  wire [3:0]    src_valid;
  wire [3:0]    src_last;
  wire [HW-1:0] src_head [4];
  wire [DW-1:0] src_data [4];

  wire          ceu_valid;
  wire          ceu_last;
  wire [HW-1:0] ceu_head;
  wire [DW-1:0] ceu_data;
  wire [31:0]   pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  swacc_cm_rsp_arbiter #(.HEAD_WIDTH(HW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .qpc_rsp_valid(src_valid[0]), .qpc_rsp_last(src_last[0]),
    .qpc_rsp_head(src_head[0]), .qpc_rsp_data(src_data[0]), .qpc_rsp_ready(src_ready[0]),
    .cqc_rsp_valid(src_valid[1]), .cqc_rsp_last(src_last[1]),
    .cqc_rsp_head(src_head[1]), .cqc_rsp_data(src_data[1]), .cqc_rsp_ready(src_ready[1]),
    .eqc_rsp_valid(src_valid[2]), .eqc_rsp_last(src_last[2]),
    .eqc_rsp_head(src_head[2]), .eqc_rsp_data(src_data[2]), .eqc_rsp_ready(src_ready[2]),
    .mapping_rsp_valid(src_valid[3]), .mapping_rsp_last(src_last[3]),
    .mapping_rsp_head(src_head[3]), .mapping_rsp_data(src_data[3]), .mapping_rsp_ready(src_ready[3]),
    .ceu_rsp_valid(ceu_valid), .ceu_rsp_head(ceu_head), .ceu_rsp_last(ceu_last),
    .ceu_rsp_data(ceu_data), .ceu_rsp_ready(ceu_ready),
    .rsp_pkt_cnt(pkt_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source drivers: present queued beats, pop on handshake, honour per-beat valid gaps.
  for (genvar g = 0; g < 4; g++) begin : drv
    beat_t         q[$];
    logic          valid = 1'b0;
    logic          last  = 1'b0;
    logic [HW-1:0] head  = '0;
    logic [DW-1:0] data  = '0;
    int            gap_cnt = 0;
    bit            hs;

    assign src_valid[g] = valid;
    assign src_last[g]  = last;
    assign src_head[g]  = head;
    assign src_data[g]  = data;

    initial begin
      forever begin
        @(negedge clk);
        hs = valid && src_ready[g];
        @(posedge clk);
        #1;
        if (rst) begin
          q.delete();
          gap_cnt = 0;
        end else if (hs) begin
          void'(q.pop_front());
          if (q.size() != 0) gap_cnt = q[0].gap;
        end
        if (!rst && q.size() != 0 && gap_cnt == 0) begin
          valid = 1'b1;
          last  = q[0].last;
          head  = q[0].head;
          data  = q[0].data;
        end else begin
          valid = 1'b0;
          if (gap_cnt > 0) gap_cnt--;
        end
      end
    end
  end

  task automatic push(input int s, input logic [HW-1:0] h, input logic [DW-1:0] d,
                      input logic l, input int gap);
    beat_t b;
    b.head = h;
    b.data = d;
    b.last = l;
    b.gap  = gap;
    case (s)
      0: drv[0].q.push_back(b);
      1: drv[1].q.push_back(b);
      2: drv[2].q.push_back(b);
      3: drv[3].q.push_back(b);
      default: ;
    endcase
  endtask

  function automatic logic [DW-1:0] mk_data(input int s, input int id, input int k);
    return DW'(s * 65536 + id * 16 + k);
  endfunction

  task automatic push_pkt(input int s, input int id, input int nb, input int gap_beat, input int gap);
    for (int k = 0; k < nb; k++)
      push(s, HW'(32'hC0DE_0000 + s * 256 + id), mk_data(s, id, k), (k == nb - 1), (k == gap_beat) ? gap : 0);
  endtask

  // Reference model: packet ownership, rotating priority, one-slot output stage.
  int            m_owner;
  int            m_ptr;
  int            m_beats;
  bit            m_full;
  logic [HW-1:0] m_head;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [31:0]   m_cnt;
  int            pkt_src_log[$];
  int            pkt_len_log[$];
  logic [DW-1:0] acc_log[$];

  // Per-cycle compare of every DUT output against the model, then advance the model.
  always @(negedge clk) begin : model
    logic [3:0] exp_rdy;
    bit         drain;
    bit         xfer;
    int         c;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_full  = 1'b0;
      m_head  = '0;
      m_data  = '0;
      m_last  = 1'b0;
      m_cnt   = 32'd0;
    end else begin
      exp_rdy = 4'b0000;
      if (m_owner >= 0 && (!m_full || ceu_ready)) exp_rdy[m_owner] = 1'b1;
      chk("src_ready", DW'(src_ready), DW'(exp_rdy));
      chk("ceu_valid", DW'(ceu_valid), DW'(m_full));
      chk("ceu_head",  DW'(ceu_head),  DW'(m_head));
      chk("ceu_data",  ceu_data,       m_data);
      chk("ceu_last",  DW'(ceu_last),  DW'(m_last));
      chk("pkt_cnt",   DW'(pkt_cnt),   DW'(m_cnt));

      drain = m_full && ceu_ready;
      xfer  = (m_owner >= 0) && exp_rdy[m_owner] && src_valid[m_owner];
      if (drain) begin
        if (m_last) m_cnt = m_cnt + 32'd1;
        acc_log.push_back(m_data);
        m_full = 1'b0;
      end
      if (xfer) begin
        m_head = src_head[m_owner];
        m_data = src_data[m_owner];
        m_last = src_last[m_owner];
        m_full = 1'b1;
        m_beats++;
        if (src_last[m_owner]) begin
          pkt_src_log.push_back(m_owner);
          pkt_len_log.push_back(m_beats);
          m_beats = 0;
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end else if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (m_owner < 0 && src_valid[c]) m_owner = c;
        end
      end
    end
  end

  task automatic clear_logs();
    pkt_src_log.delete();
    pkt_len_log.delete();
    acc_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    ceu_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int c;
    c = 0;
    while (c < max_cyc &&
           !(drv[0].q.size() == 0 && drv[1].q.size() == 0 && drv[2].q.size() == 0 &&
             drv[3].q.size() == 0 && src_valid == 4'b0000 && !ceu_valid && m_owner < 0)) begin
      @(posedge clk);
      c++;
    end
    n_cmp++;
    if (c >= max_cyc) begin
      n_err++;
      $display("FAIL %s_drain: still busy after %0d cycles", name, max_cyc);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_order(input string name, input int exp_src[$], input int exp_len);
    chk({name, "_npkt"}, DW'(pkt_src_log.size()), DW'(exp_src.size()));
    for (int i = 0; i < exp_src.size(); i++) begin
      chk({name, "_src"}, DW'((i < pkt_src_log.size()) ? pkt_src_log[i] : -1), DW'(exp_src[i]));
      chk({name, "_len"}, DW'((i < pkt_len_log.size()) ? pkt_len_log[i] : -1), DW'(exp_len));
    end
  endtask

  initial begin
    int       pat[7];
    int       exp_q[$];
    logic [HW-1:0] h_a5;
    pat  = '{1, 0, 0, 1, 1, 0, 1};
    h_a5 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5;

    // Reset state
    #12;
    chk("rst_valid", DW'(ceu_valid), DW'(0));
    chk("rst_head",  DW'(ceu_head),  DW'(0));
    chk("rst_data",  ceu_data,       DW'(0));
    chk("rst_last",  DW'(ceu_last),  DW'(0));
    chk("rst_ready", DW'(src_ready), DW'(0));
    chk("rst_cnt",   DW'(pkt_cnt),   DW'(0));
    @(posedge clk);
    #3 rst = 1'b0;

    // Single source, one-beat packet with exact bubble/latency timing
    clear_logs();
    @(posedge clk);
    #2 push(0, h_a5, DW'(32'h0000_5A5A), 1'b1, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_ready_T",   DW'(src_ready), DW'(4'b0000));
    @(negedge clk);
    chk("t1_ready_T1",  DW'(src_ready), DW'(4'b0001));
    chk("t1_valid_T1",  DW'(ceu_valid), DW'(0));
    @(negedge clk);
    chk("t1_valid_T2",  DW'(ceu_valid), DW'(1));
    chk("t1_head_T2",   DW'(ceu_head),  DW'(h_a5));
    chk("t1_last_T2",   DW'(ceu_last),  DW'(1));
    chk("t1_cnt_T2",    DW'(pkt_cnt),   DW'(0));
    chk("t1_ready_T2",  DW'(src_ready), DW'(4'b0000));
    @(negedge clk);
    chk("t1_cnt_T3",    DW'(pkt_cnt),   DW'(1));
    chk("t1_valid_T3",  DW'(ceu_valid), DW'(0));
    wait_drain("t1", 50);

    // Fairness: all sources busy with 2-beat packets
    do_reset();
    clear_logs();
    @(posedge clk);
    #2;
    for (int s = 0; s < 4; s++) push_pkt(s, 1, 2, -1, 0);
    push_pkt(0, 2, 2, -1, 0);
    push_pkt(1, 2, 2, -1, 0);
    wait_drain("t2", 200);
    exp_q = '{0, 1, 2, 3, 0, 1};
    chk_order("t2", exp_q, 2);
    chk("t2_beats", DW'(acc_log.size()), DW'(12));
    chk("t2_cnt",   DW'(pkt_cnt),        DW'(6));

    // Pointer rotation: CQC and MAPPING at reset, CQC re-requests
    do_reset();
    clear_logs();
    @(posedge clk);
    #2;
    push_pkt(1, 1, 1, -1, 0);
    push_pkt(3, 1, 1, -1, 0);
    push_pkt(1, 2, 1, -1, 0);
    wait_drain("t3", 100);
    exp_q = '{1, 3, 1};
    chk_order("t3", exp_q, 1);
    chk("t3_cnt", DW'(pkt_cnt), DW'(3));

    // Backpressure on a 4-beat EQC packet
    do_reset();
    clear_logs();
    @(posedge clk);
    #2 push_pkt(2, 1, 4, -1, 0);
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1 ceu_ready = pat[i][0];
      if (i == 2) begin
        @(negedge clk);
        chk("t4_hold_d1",  ceu_data,        DW'(32'h0002_0011));
        chk("t4_hold_vld", DW'(ceu_valid),  DW'(1));
      end
      if (i == 5) begin
        @(negedge clk);
        chk("t4_hold_d3",  ceu_data,        DW'(32'h0002_0013));
        chk("t4_cnt_pre",  DW'(pkt_cnt),    DW'(0));
      end
    end
    @(posedge clk);
    #1 ceu_ready = 1'b1;
    wait_drain("t4", 100);
    chk("t4_nbeat", DW'(acc_log.size()), DW'(4));
    for (int k = 0; k < 4; k++)
      chk("t4_beat", (k < acc_log.size()) ? acc_log[k] : DW'(0), DW'(32'h0002_0010 + k));
    chk("t4_cnt", DW'(pkt_cnt), DW'(1));

    // Mid-packet valid gap on QPC with MAPPING waiting
    do_reset();
    clear_logs();
    @(posedge clk);
    #2;
    push_pkt(0, 1, 3, 1, 3);
    push_pkt(3, 1, 1, -1, 0);
    wait_drain("t5", 100);
    chk("t5_npkt", DW'(pkt_src_log.size()), DW'(2));
    chk("t5_src0", DW'((pkt_src_log.size() > 0) ? pkt_src_log[0] : -1), DW'(0));
    chk("t5_len0", DW'((pkt_len_log.size() > 0) ? pkt_len_log[0] : -1), DW'(3));
    chk("t5_src1", DW'((pkt_src_log.size() > 1) ? pkt_src_log[1] : -1), DW'(3));
    chk("t5_cnt",  DW'(pkt_cnt), DW'(2));

    // Reset in the middle of a 3-beat QPC packet
    clear_logs();
    @(posedge clk);
    #2 push_pkt(0, 2, 3, -1, 0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", DW'(ceu_valid), DW'(0));
    chk("t6_head",  DW'(ceu_head),  DW'(0));
    chk("t6_data",  ceu_data,       DW'(0));
    chk("t6_last",  DW'(ceu_last),  DW'(0));
    chk("t6_ready", DW'(src_ready), DW'(0));
    chk("t6_cnt",   DW'(pkt_cnt),   DW'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    clear_logs();
    @(posedge clk);
    #2 push_pkt(0, 3, 1, -1, 0);
    wait_drain("t6", 50);
    chk("t6_npkt", DW'(pkt_src_log.size()), DW'(1));
    chk("t6_src",  DW'((pkt_src_log.size() > 0) ? pkt_src_log[0] : -1), DW'(0));
    chk("t6_beat", (acc_log.size() > 0) ? acc_log[0] : DW'(0), DW'(32'h30));
    chk("t6_cnt2", DW'(pkt_cnt), DW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/swacc_cm_rsp_arbiter.md
# swacc_cm_rsp_arbiter

Packet-level round-robin arbiter in the SWAccCMCtl context-management path. It merges the four per-thread response streams (QPC, CQC, EQC, ICM mapping) into the single response channel toward the CEU. A packet (head + data beats, terminated by last) is never interleaved with another. The merged output is registered through a one-entry pipeline stage.

## Interface
- HEAD_WIDTH, default `CEU_CXT_HEAD_WIDTH (128): response head width.
- DATA_WIDTH, default `CEU_CXT_DATA_WIDTH (256): response data beat width.
- Clocking (already decided): reset rst, asynchronous, active-high; clock clk.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- qpc_rsp_valid / qpc_rsp_last  in  1 / 1  source 0 handshake and end-of-packet.
- qpc_rsp_head / qpc_rsp_data  in  HEAD_WIDTH / DATA_WIDTH  source 0 payload.
- qpc_rsp_ready  out  1  source 0 accept.
- cqc_rsp_*  same set as qpc_rsp_*  source 1.
- eqc_rsp_*  same set as qpc_rsp_*  source 2.
- mapping_rsp_*  same set as qpc_rsp_*  source 3.
- ceu_rsp_valid  out  1  merged response valid.
- ceu_rsp_head  out  HEAD_WIDTH  merged head, passed unchanged.
- ceu_rsp_last  out  1  merged end-of-packet.
- ceu_rsp_data  out  DATA_WIDTH  merged data.
- ceu_rsp_ready  in  1  CEU accept.
- rsp_pkt_cnt  out  32  count of packets delivered to CEU (last beats accepted by CEU); wraps 0xFFFFFFFF -> 0.

## Operation
- State machine cur_state with two states:
  - IDLE_s (reset state).
  - LOCK_s, which holds a registered grant_idx[1:0].
- Priority pointer rr_ptr[1:0], reset 0: the index with highest priority in the next arbitration.
- In IDLE_s, if any source valid is high:
  - Choose the first valid index scanning rr_ptr, rr_ptr+1, ... (mod 4).
  - Register it into grant_idx and move to LOCK_s.
  - No source ready is asserted in IDLE_s.
- In LOCK_s:
  - Only the granted source's ready may be high; it equals acc = !ceu_rsp_valid || ceu_rsp_ready.
  - All other readies are 0.
  - A beat transfers when the granted valid and acc are both high. It is loaded into the output register: head, data and last are captured, and ceu_rsp_valid is set to 1.
- When a granted beat with last=1 transfers:
  - Next state is IDLE_s.
  - rr_ptr becomes grant_idx+1 (mod 4, so 3 -> 0).
- The output register clears ceu_rsp_valid when ceu_rsp_ready && ceu_rsp_valid and no new beat loads in the same cycle. Head, data and last hold their last loaded value.
- rsp_pkt_cnt increments by 1 on every cycle where ceu_rsp_valid && ceu_rsp_ready && ceu_rsp_last.
- Source valid dropping mid-packet: the grant is held and no beat transfers; the arbiter waits for that source indefinitely.
- Non-granted sources are never dropped. Their valid and payload must stay stable until they are granted, per standard valid/ready rules.

## Timing
- Reset values: ceu_rsp_valid 0, ceu_rsp_head 0, ceu_rsp_data 0, ceu_rsp_last 0, all *_rsp_ready 0, rsp_pkt_cnt 0, rr_ptr 0, cur_state IDLE_s.
- Arbitration cost: one bubble cycle per packet.
  - Valid seen in IDLE_s at cycle T gives a granted ready at T+1.
  - The first beat appears on ceu_rsp_valid at T+2.
- Latency source-accept -> CEU-visible: 1 cycle.
- Throughput inside a packet: 1 beat/cycle while ceu_rsp_ready=1, including when the output register drains and refills in the same cycle.
- Back-to-back packets: the last beat accepted at cycle L returns to IDLE_s at L+1. The next grant is registered there, and the next packet's first ready comes at L+2.
- Backpressure: with ceu_rsp_ready=0 and the output register full, the granted ready is 0. Output payload holds stable until accepted.
- Simultaneous requests: exactly one grant. The others keep waiting with ready=0.
- Reset mid-packet: all state clears asynchronously, including any partially delivered packet. After deassertion, arbitration restarts from source 0.

## Test plan
- Single source: QPC sends a 1-beat packet, head=0x...A5, last=1, ceu_rsp_ready=1.
  - qpc_rsp_ready is high for 1 cycle at T+1.
  - CEU sees valid at T+2 with head 0x...A5 and last=1.
  - rsp_pkt_cnt goes 0 -> 1.
- Fairness: all four sources hold valid continuously with 2-beat packets.
  - Grant order is 0,1,2,3,0,1.
  - No interleaving; each packet is exactly 2 consecutive CEU beats.
- Pointer rotation: CQC and MAPPING both valid at reset (rr_ptr=0).
  - CQC is granted first, then rr_ptr=2, then MAPPING.
  - If CQC re-requests immediately, MAPPING is still served before CQC.
- Backpressure: EQC sends a 4-beat packet while ceu_rsp_ready toggles 1,0,0,1,1,0,1.
  - CEU receives beats D0..D3 in order, with no duplication or loss.
  - Payload is stable during every ready=0 cycle.
  - rsp_pkt_cnt increments exactly once, on the D3 accept.
- Mid-packet gap: QPC drops valid for 3 cycles between beats 1 and 2 while MAPPING is valid.
  - The grant stays on QPC and MAPPING's ready stays 0.
  - MAPPING is granted only after QPC's last beat.
- Reset mid-packet: rst asserted after beat 1 of 3.
  - All outputs go to 0 immediately; rsp_pkt_cnt=0.
  - After release, a new 1-beat QPC packet is delivered normally.
